// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter: round-robin shared bit-serial adder, one half-adder pair sequenced LSB first
module serial_add_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             owner,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0] sa, sb, res;
    logic [CW-1:0]    cnt;
    logic             c, last_owner;
    logic             any, win, s1, c1, sbit, c2, last;

    assign any  = req0 | req1;
    // On a tie the requester that did not win last time goes first
    assign win  = (req0 & req1) ? ~last_owner : req1;
    assign s1   = sa[0] ^ sb[0];
    assign c1   = sa[0] & sb[0];
    assign sbit = s1 ^ c;
    assign c2   = s1 & c;
    assign last = cnt == LAST;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = any ? ADD : IDLE;
            ADD:     state_nx = last ? DONE : ADD;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            cnt        <= '0;
            c          <= 1'b0;
            last_owner <= 1'b1;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            owner      <= 1'b0;
            sum        <= '0;
            carry      <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: if (any) begin
                    sa         <= win ? a1 : a0;
                    sb         <= win ? b1 : b0;
                    res        <= '0;
                    cnt        <= '0;
                    c          <= 1'b0;
                    sum        <= '0;
                    carry      <= 1'b0;
                    owner      <= win;
                    last_owner <= win;
                    gnt0       <= ~win;
                    gnt1       <= win;
                    busy       <= 1'b1;
                end
                ADD: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= {sbit, res[WIDTH-1:1]};
                    c   <= c1 | c2;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        sum   <= {sbit, res[WIDTH-1:1]};
                        carry <= c1 | c2;
                        done  <= 1'b1;
                    end
                end
                DONE:    busy <= 1'b0;
                default: busy <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_arbiter.sv
// tb_serial_add_arbiter: directed and random checks of the shared serial adder
module tb_serial_add_arbiter;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         gnt0, gnt1, busy, done, owner, carry;
    logic [W-1:0] sum;
    int           checks = 0;
    int           errors = 0;

    serial_add_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
        .owner(owner), .sum(sum), .carry(carry)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({gnt0, gnt1, busy, done, owner, carry} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b want 000000", {gnt0, gnt1, busy, done, owner, carry});
        end
        checks++;
        if (sum !== '0) begin
            errors++;
            $display("FAIL reset_sum got %h want 00", sum);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic bad;
        a0 = 8'h5A; b0 = 8'h3C; req0 = 1'b1;
        tick();
        req0 = 1'b0;
        checks++;
        if ({gnt0, gnt1, busy} !== 3'b101) begin
            errors++;
            $display("FAIL basic_grant got %b want 101", {gnt0, gnt1, busy});
        end
        bad = 1'b0;
        for (int i = 1; i < W; i++) begin
            tick();
            if (done !== 1'b0 || gnt0 !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL basic_early got done/gnt/busy activity want quiet busy");
        end
        tick();
        checks++;
        if ({done, owner, carry, sum} !== {1'b1, 1'b0, 1'b0, 8'h96}) begin
            errors++;
            $display("FAIL basic_result got done=%b owner=%b c=%b sum=%h want 1 0 0 96", done, owner, carry, sum);
        end
        tick();
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL basic_end got done/busy=%b want 00", {done, busy});
        end
    endtask

    task automatic test_req1();
        logic [W-1:0] va[2] = '{8'hFF, 8'h00};
        logic [W-1:0] vb[2] = '{8'h01, 8'h00};
        logic         vc[2] = '{1'b1, 1'b0};
        for (int k = 0; k < 2; k++) begin
            a1 = va[k]; b1 = vb[k]; req1 = 1'b1;
            tick();
            req1 = 1'b0;
            checks++;
            if ({gnt0, gnt1, sum, carry} !== {2'b01, 8'h00, 1'b0}) begin
                errors++;
                $display("FAIL req1_grant%0d got g=%b%b sum=%h c=%b want 01 00 0", k, gnt0, gnt1, sum, carry);
            end
            repeat (W) tick();
            checks++;
            if ({done, owner, carry, sum} !== {1'b1, 1'b1, vc[k], 8'h00}) begin
                errors++;
                $display("FAIL req1_result%0d got done=%b owner=%b c=%b sum=%h want 1 1 %b 00", k, done, owner, carry, sum, vc[k]);
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        int n;
        rst_n = 1'b0;
        a0 = 8'h10; b0 = 8'h20; a1 = 8'h80; b1 = 8'h80;
        req0 = 1'b1; req1 = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (gnt0 !== 1'b1 && gnt1 !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            checks++;
            if (n >= 20) begin
                errors++;
                $display("FAIL rr_timeout%0d got no grant want grant", k);
            end
            checks++;
            if ({gnt0, gnt1} !== ((k % 2 == 1) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL rr_order%0d got %b%b want %s", k, gnt0, gnt1, (k % 2 == 1) ? "01" : "10");
            end
            if (k > 0) begin
                checks++;
                if (W + n != 10) begin
                    errors++;
                    $display("FAIL rr_period%0d got %0d want 10", k, W + n);
                end
            end
            repeat (W) tick();
            if (k == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            checks++;
            if ((k % 2 == 0 && {done, carry, sum} !== {1'b1, 1'b0, 8'h30}) ||
                (k % 2 == 1 && {done, carry, sum} !== {1'b1, 1'b1, 8'h00})) begin
                errors++;
                $display("FAIL rr_result%0d got done=%b c=%b sum=%h", k, done, carry, sum);
            end
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        logic bad;
        a1 = 8'h11; b1 = 8'h22; req1 = 1'b1;
        tick();
        req1 = 1'b0;
        checks++;
        if (gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL rmid_grant got %b want 1", gnt1);
        end
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt0, gnt1, busy, done, owner, carry, sum} !== '0) begin
            errors++;
            $display("FAIL rmid_clear got busy=%b owner=%b sum=%h want all 0", busy, owner, sum);
        end
        tick();
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rmid_nodone got done/busy after abort want none");
        end
        a0 = 8'h40; b0 = 8'h41; req0 = 1'b1;
        tick();
        req0 = 1'b0;
        checks++;
        if (gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL rmid_regrant got %b want 1", gnt0);
        end
        repeat (W) tick();
        checks++;
        if ({done, owner, carry, sum} !== {1'b1, 1'b0, 1'b0, 8'h81}) begin
            errors++;
            $display("FAIL rmid_result got done=%b owner=%b c=%b sum=%h want 1 0 0 81", done, owner, carry, sum);
        end
        tick();
    endtask

    task automatic test_operand_change();
        logic bad;
        a0 = 8'hC8; b0 = 8'h64; req0 = 1'b1;
        tick();
        req0 = 1'b0;
        checks++;
        if (gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL opch_grant got %b want 1", gnt0);
        end
        tick();
        a0 = 8'h00; b0 = 8'h00; a1 = 8'h01; b1 = 8'h02; req1 = 1'b1;
        bad = 1'b0;
        for (int i = 2; i < W; i++) begin
            tick();
            if (gnt1 !== 1'b0) bad = 1'b1;
        end
        tick();
        if (gnt1 !== 1'b0) bad = 1'b1;
        checks++;
        if ({done, owner, carry, sum} !== {1'b1, 1'b0, 1'b1, 8'h2C}) begin
            errors++;
            $display("FAIL opch_result got done=%b owner=%b c=%b sum=%h want 1 0 1 2c", done, owner, carry, sum);
        end
        tick();
        if (gnt1 !== 1'b0) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL opch_early got gnt1 before idle want none");
        end
        tick();
        req1 = 1'b0;
        checks++;
        if (gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL opch_regrant got %b want 1", gnt1);
        end
        repeat (W) tick();
        checks++;
        if ({done, owner, carry, sum} !== {1'b1, 1'b1, 1'b0, 8'h03}) begin
            errors++;
            $display("FAIL opch_second got done=%b owner=%b c=%b sum=%h want 1 1 0 03", done, owner, carry, sum);
        end
        tick();
    endtask

    task automatic test_random();
        logic [W:0]   expv;
        logic [W-1:0] ra, rb;
        logic         r, both;
        int           n;
        for (int it = 0; it < 2000; it++) begin
            r = it[0];
            ra = W'($urandom);
            rb = W'($urandom);
            expv = {1'b0, ra} + {1'b0, rb};
            if (r) begin a1 = ra; b1 = rb; req1 = 1'b1; end
            else   begin a0 = ra; b0 = rb; req0 = 1'b1; end
            tick();
            req0 = 1'b0;
            req1 = 1'b0;
            checks++;
            if ({gnt0, gnt1} !== (r ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL rnd_grant%0d got %b%b want %s", it, gnt0, gnt1, r ? "01" : "10");
            end
            n = 0;
            both = 1'b0;
            while (done !== 1'b1 && n < W + 4) begin
                tick();
                n++;
                if (gnt0 === 1'b1 && gnt1 === 1'b1) both = 1'b1;
            end
            checks++;
            if (n != W || both) begin
                errors++;
                $display("FAIL rnd_latency%0d got %0d both=%b want %0d 0", it, n, both, W);
            end
            checks++;
            if ({carry, sum} !== expv || owner !== r) begin
                errors++;
                $display("FAIL rnd_result%0d a=%h b=%h got c=%b sum=%h owner=%b want %b %h %b", it, ra, rb, carry, sum, owner, expv[W], expv[W-1:0], r);
            end
            tick();
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL rnd_pulse%0d got done=%b want 0", it, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_req1();
        test_round_robin();
        test_reset_mid();
        test_operand_change();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
